muladdsub_acc: RTL

MULADDSUB_ACC -- requirements
Module: muladdsub_acc

---
 rtl/muladdsub_pkg.sv | 12 +
 rtl/dsp_pipe_reg.sv | 30 +++
 rtl/muladdsub_acc.sv | 126 ++++++++++++
 3 files changed

// File: rtl/muladdsub_pkg.sv
// Shared limits and helpers for the multiply / add-subtract / accumulate block.
package muladdsub_pkg;

  localparam int unsigned OPW_MIN = 32'd2;
  localparam int unsigned OPW_MAX = 32'd36;

  // Enabled cycles from sample capture to z / out_valid.
  function automatic int unsigned calc_latency(input int unsigned in_reg, input int unsigned pipe_reg);
    return in_reg + pipe_reg + 32'd1;
  endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional enabled pipeline stage with synchronous reset; collapses to a wire when bypassed.
module dsp_pipe_reg #(
  parameter int W      = 1,
  parameter bit BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (BYPASS) begin : g_bypass
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, en};
    assign o_q = i_d;
  end else begin : g_reg
    logic [W-1:0] r_q;
    // Stage register: reset wins over enable.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_q <= '0;
      end else if (en) begin
        r_q <= i_d;
      end
    end
    assign o_q = r_q;
  end

endmodule

// File: rtl/muladdsub_acc.sv
// Multiply, then add/subtract into a self-seeding accumulator with sticky overflow.
module muladdsub_acc
  import muladdsub_pkg::*;
#(
  parameter int A_W      = 18,
  parameter int B_W      = 18,
  parameter int Z_W      = 54,
  parameter int IN_REG   = 0,
  parameter int PIPE_REG = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           strobe,
  input  logic           ce,
  input  logic           in_valid,
  input  logic           is_signed,
  input  logic           addsub,
  input  logic           cin,
  input  logic           loadc,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [Z_W-1:0] c,
  output logic [Z_W-1:0] z,
  output logic           out_valid,
  output logic           ovf
);

  if (A_W < OPW_MIN || A_W > OPW_MAX) begin : g_bad_a_w
    $error("muladdsub_acc: A_W out of range");
  end
  if (B_W < OPW_MIN || B_W > OPW_MAX) begin : g_bad_b_w
    $error("muladdsub_acc: B_W out of range");
  end
  if (Z_W < A_W + B_W + 1) begin : g_bad_z_w
    $error("muladdsub_acc: Z_W must be at least A_W+B_W+1");
  end

  localparam int S0_W = 5 + Z_W + B_W + A_W;
  localparam int S1_W = 5 + Z_W + Z_W;
  localparam int XW   = Z_W + 2;

  logic              w_en;
  logic [S0_W-1:0]   w_s0, w_s1;
  logic [S1_W-1:0]   w_t1, w_t2;
  logic              w_v1, w_sg1, w_sub1, w_cin1, w_ld1;
  logic [A_W-1:0]    w_a1;
  logic [B_W-1:0]    w_b1;
  logic [Z_W-1:0]    w_c1, w_a_ext, w_b_ext, w_p1;
  logic              w_v2, w_sg2, w_sub2, w_cin2, w_ld2;
  logic [Z_W-1:0]    w_c2, w_p2, w_base;
  logic [XW-1:0]     w_base_x, w_p_x, w_cin_x, w_sum_x;
  logic [2:0]        w_top3;
  logic              w_ovf_now, w_ovf_next;
  logic [Z_W-1:0]    r_z;
  logic              r_out_valid, r_ovf;

  assign w_en = ce & strobe;

  // Controls ride alongside their operands through both optional stages.
  assign w_s0 = {in_valid, is_signed, addsub, cin, loadc, c, b, a};

  dsp_pipe_reg #(.W(S0_W), .BYPASS(IN_REG == 0)) u_in_reg (
    .clk (clk), .rst (rst), .en (w_en), .i_d (w_s0), .o_q (w_s1)
  );

  assign {w_v1, w_sg1, w_sub1, w_cin1, w_ld1, w_c1, w_b1, w_a1} = w_s1;
  assign w_a_ext = {{(Z_W-A_W){w_sg1 & w_a1[A_W-1]}}, w_a1};
  assign w_b_ext = {{(Z_W-B_W){w_sg1 & w_b1[B_W-1]}}, w_b1};
  assign w_p1    = w_a_ext * w_b_ext;
  assign w_t1    = {w_v1, w_sg1, w_sub1, w_cin1, w_ld1, w_c1, w_p1};

  dsp_pipe_reg #(.W(S1_W), .BYPASS(PIPE_REG == 0)) u_pipe_reg (
    .clk (clk), .rst (rst), .en (w_en), .i_d (w_t1), .o_q (w_t2)
  );

  assign {w_v2, w_sg2, w_sub2, w_cin2, w_ld2, w_c2, w_p2} = w_t2;

  // Two guard bits expose both unsigned carry/borrow and signed range escape.
  always_comb begin
    w_base   = r_z;
    if (w_ld2) begin
      w_base = w_c2;
    end else begin
      w_base = r_z;
    end
    w_base_x = {{2{w_sg2 & w_base[Z_W-1]}}, w_base};
    w_p_x    = {{2{w_sg2 & w_p2[Z_W-1]}}, w_p2};
    w_cin_x  = {{(XW-1){1'b0}}, w_cin2};
    if (w_sub2) begin
      w_sum_x = w_base_x - w_p_x + w_cin_x;
    end else begin
      w_sum_x = w_base_x + w_p_x + w_cin_x;
    end
    w_top3 = w_sum_x[Z_W+1:Z_W-1];
    if (w_sg2) begin
      w_ovf_now = (w_top3 != 3'b000) && (w_top3 != 3'b111);
    end else begin
      w_ovf_now = (w_sum_x[Z_W+1:Z_W] != 2'b00);
    end
    if (w_ld2) begin
      w_ovf_next = w_ovf_now;
    end else begin
      w_ovf_next = r_ovf | w_ovf_now;
    end
  end

  // Accumulator stage: idle samples keep z/ovf and only drop out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z         <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= w_v2;
      if (w_v2) begin
        r_z   <= w_sum_x[Z_W-1:0];
        r_ovf <= w_ovf_next;
      end
    end
  end

  assign z         = r_z;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;

endmodule
